// File: rtl/cpuy_pkg.sv
// Shared definitions for the cpuy core: sequencer state encoding and widths.
package cpuy_pkg;

    localparam int STATE_W = 3;

    // Codes 6 and 7 are unused and fall back to S_FETCH.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 3'd0,
        S_OPERAND = 3'd1,
        S_RAM     = 3'd2,
        S_EXEC    = 3'd3,
        S_WBHI    = 3'd4,
        S_STACK   = 3'd5
    } state_t;

endpackage

// File: rtl/cpuy_sequencer.sv
// cpuy instruction sequencer: fetches opcode/operand bytes from program ROM,
// optionally replaces the operand with a RAM byte, then steps through execute,
// high-byte writeback and stack phases while owning the program counter.
module cpuy_sequencer
    import cpuy_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic                rom_req,
    output logic [PC_WIDTH-1:0] rom_addr,
    input  logic                rom_ack,
    input  logic [7:0]          rom_data,
    output logic                ram_req,
    output logic [7:0]          ram_addr,
    input  logic                ram_ack,
    input  logic [7:0]          ram_rdata,
    output logic [7:0]          opcode_q,
    output logic [7:0]          operand_q,
    input  logic                ram_operand,
    input  logic                alu_multibyte_result,
    input  logic                jump_operation,
    input  logic                jump_condition,
    input  logic                stack_operation,
    input  logic                stack_direction,
    output logic                exec_en,
    output logic                wb_hi,
    output logic                sp_push,
    output logic                sp_pop,
    output logic                instr_done,
    output logic [PC_WIDTH-1:0] pc,
    output logic [STATE_W-1:0]  state
);

    state_t state_r;

    // Sequencer FSM together with the pc, opcode and operand registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            pc        <= RESET_PC;
            opcode_q  <= 8'h00;
            operand_q <= 8'h00;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (run && rom_ack) begin
                        opcode_q <= rom_data;
                        pc       <= pc + PC_WIDTH'(1);
                        state_r  <= S_OPERAND;
                    end
                end
                S_OPERAND: begin
                    if (rom_ack) begin
                        operand_q <= rom_data;
                        pc        <= pc + PC_WIDTH'(1);
                        state_r   <= ram_operand ? S_RAM : S_EXEC;
                    end
                end
                S_RAM: begin
                    if (ram_ack) begin
                        operand_q <= ram_rdata;
                        state_r   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (jump_operation && jump_condition) begin
                        pc <= PC_WIDTH'(operand_q);
                    end
                    if (alu_multibyte_result) begin
                        state_r <= S_WBHI;
                    end else if (stack_operation) begin
                        state_r <= S_STACK;
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_WBHI: begin
                    state_r <= stack_operation ? S_STACK : S_FETCH;
                end
                S_STACK: begin
                    state_r <= S_FETCH;
                end
                default: begin
                    state_r <= S_FETCH;
                end
            endcase
        end
    end

    // Requests and strobes decode the registered state; instr_done also looks
    // at the ucode flags, which are stable because opcode_q is frozen.
    // Unused codes 6/7 are not an instruction, so they raise no instr_done.
    always_comb begin
        rom_req    = ((state_r == S_FETCH) && run) || (state_r == S_OPERAND);
        ram_req    = (state_r == S_RAM);
        exec_en    = (state_r == S_EXEC);
        wb_hi      = (state_r == S_WBHI);
        sp_push    = (state_r == S_STACK) && stack_direction;
        sp_pop     = (state_r == S_STACK) && !stack_direction;
        instr_done = ((state_r == S_EXEC) && !alu_multibyte_result && !stack_operation)
                   || ((state_r == S_WBHI) && !stack_operation)
                   || (state_r == S_STACK);
    end

    assign rom_addr = pc;
    assign ram_addr = operand_q;
    assign state    = state_r;

endmodule

// File: tb/tb_cpuy_sequencer.sv
// Directed testbench for cpuy_sequencer with hand-computed expectations.
module tb_cpuy_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       rom_req;
    logic [7:0] rom_addr;
    logic       rom_ack;
    logic [7:0] rom_data;
    logic       ram_req;
    logic [7:0] ram_addr;
    logic       ram_ack;
    logic [7:0] ram_rdata;
    logic [7:0] opcode_q;
    logic [7:0] operand_q;
    logic       ram_operand;
    logic       alu_multibyte_result;
    logic       jump_operation;
    logic       jump_condition;
    logic       stack_operation;
    logic       stack_direction;
    logic       exec_en;
    logic       wb_hi;
    logic       sp_push;
    logic       sp_pop;
    logic       instr_done;
    logic [7:0] pc;
    logic [2:0] state;

    int n_cmp  = 0;
    int n_fail = 0;

    cpuy_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .run                  (run),
        .rom_req              (rom_req),
        .rom_addr             (rom_addr),
        .rom_ack              (rom_ack),
        .rom_data             (rom_data),
        .ram_req              (ram_req),
        .ram_addr             (ram_addr),
        .ram_ack              (ram_ack),
        .ram_rdata            (ram_rdata),
        .opcode_q             (opcode_q),
        .operand_q            (operand_q),
        .ram_operand          (ram_operand),
        .alu_multibyte_result (alu_multibyte_result),
        .jump_operation       (jump_operation),
        .jump_condition       (jump_condition),
        .stack_operation      (stack_operation),
        .stack_direction      (stack_direction),
        .exec_en              (exec_en),
        .wb_hi                (wb_hi),
        .sp_push              (sp_push),
        .sp_pop               (sp_pop),
        .instr_done           (instr_done),
        .pc                   (pc),
        .state                (state)
    );

    // Free-running core clock.
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Fetch an opcode/operand pair with same-cycle acks; returns after operand edge.
    task automatic fetch_pair(input logic [7:0] op, input logic [7:0] opd);
        run      = 1'b1;
        rom_ack  = 1'b1;
        rom_data = op;
        tick();
        rom_data = opd;
        tick();
        rom_ack  = 1'b0;
        run      = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Linear sequence of directed steps.
    initial begin
        rst_n = 1'b0; run = 1'b0; rom_ack = 1'b0; rom_data = 8'h00;
        ram_ack = 1'b0; ram_rdata = 8'h00; ram_operand = 1'b0;
        alu_multibyte_result = 1'b0; jump_operation = 1'b0; jump_condition = 1'b0;
        stack_operation = 1'b0; stack_direction = 1'b0;

        // Reset and idle
        tick(); tick();
        check_output("rst_state", 32'(state), 32'd0);
        check_output("rst_pc", 32'(pc), 32'h00);
        rst_n = 1'b1;
        tick(); tick(); tick();
        check_output("idle_state", 32'(state), 32'd0);
        check_output("idle_rom_req", 32'(rom_req), 32'd0);
        check_output("idle_strobes", 32'({exec_en, wb_hi, sp_push, sp_pop, instr_done, ram_req}), 32'd0);
        check_output("idle_regs", 32'({pc, opcode_q, operand_q}), 32'h000000);

        // Plain ALU op
        run = 1'b1; rom_ack = 1'b1; rom_data = 8'h12;
        #1;
        check_output("alu_rom_req_fetch", 32'(rom_req), 32'd1);
        tick();
        rom_data = 8'h34;
        check_output("alu_state_operand", 32'(state), 32'd1);
        check_output("alu_opcode", 32'(opcode_q), 32'h12);
        check_output("alu_pc1", 32'(pc), 32'h01);
        tick();
        rom_ack = 1'b0; run = 1'b0;
        check_output("alu_state_exec", 32'(state), 32'd3);
        check_output("alu_operand", 32'(operand_q), 32'h34);
        check_output("alu_exec_done", 32'({exec_en, instr_done}), 32'b11);
        check_output("alu_pc2", 32'(pc), 32'h02);
        tick();
        check_output("alu_back_fetch", 32'(state), 32'd0);
        check_output("alu_strobes_off", 32'({exec_en, instr_done, rom_req}), 32'd0);

        // RAM operand with delayed ack, multibyte result
        ram_operand = 1'b1; alu_multibyte_result = 1'b1;
        fetch_pair(8'h56, 8'h78);
        check_output("ram_state", 32'(state), 32'd2);
        check_output("ram_req_addr", 32'({ram_req, ram_addr}), 32'h178);
        tick(); tick();
        check_output("ram_wait", 32'({state, ram_req}), 32'({3'd2, 1'b1}));
        ram_ack = 1'b1; ram_rdata = 8'hA5;
        tick();
        ram_ack = 1'b0;
        check_output("ram_exec_operand", 32'(operand_q), 32'hA5);
        check_output("ram_exec", 32'({exec_en, instr_done, wb_hi}), 32'b100);
        tick();
        check_output("ram_wbhi", 32'({state, wb_hi, instr_done, exec_en}), 32'({3'd4, 3'b110}));
        tick();
        check_output("ram_after", 32'({state, wb_hi}), 32'd0);
        check_output("ram_pc", 32'(pc), 32'h04);
        ram_operand = 1'b0; alu_multibyte_result = 1'b0;

        // Jumps: move to 0xFC, then taken jump at pc=0xFE
        jump_operation = 1'b1; jump_condition = 1'b1;
        fetch_pair(8'h80, 8'hFC);
        check_output("jmp0_pc_exec", 32'(pc), 32'h06);
        tick();
        check_output("jmp0_pc", 32'(pc), 32'hFC);
        fetch_pair(8'h81, 8'h40);
        check_output("jmp1_pc_exec", 32'(pc), 32'hFE);
        tick();
        check_output("jmp1_taken_pc", 32'(pc), 32'h40);
        fetch_pair(8'h82, 8'hFC);
        tick();
        check_output("jmp2_pc", 32'(pc), 32'hFC);
        jump_condition = 1'b0;
        fetch_pair(8'h83, 8'h40);
        tick();
        check_output("jmp3_not_taken_pc", 32'(pc), 32'hFE);
        fetch_pair(8'h84, 8'h11);
        check_output("jmp4_wrap_pc", 32'(pc), 32'h00);
        tick();
        jump_operation = 1'b0;

        // Stack push then pop
        stack_operation = 1'b1; stack_direction = 1'b1;
        fetch_pair(8'h90, 8'h01);
        check_output("push_exec", 32'({exec_en, instr_done, sp_push, sp_pop}), 32'b1000);
        tick();
        check_output("push_stack", 32'({state, sp_push, sp_pop, instr_done, exec_en}), 32'({3'd5, 4'b1010}));
        tick();
        check_output("push_after", 32'({state, sp_push, sp_pop}), 32'd0);
        stack_direction = 1'b0;
        fetch_pair(8'h91, 8'h02);
        check_output("pop_exec", 32'({exec_en, instr_done, sp_push, sp_pop}), 32'b1000);
        tick();
        check_output("pop_stack", 32'({state, sp_push, sp_pop, instr_done, exec_en}), 32'({3'd5, 4'b0110}));
        tick();
        check_output("pop_after", 32'({state, sp_push, sp_pop}), 32'd0);
        check_output("stack_pc", 32'(pc), 32'h04);
        stack_operation = 1'b0;

        // Reset in the middle of a RAM read
        ram_operand = 1'b1;
        fetch_pair(8'hA0, 8'h33);
        check_output("mid_ram_req", 32'({state, ram_req}), 32'({3'd2, 1'b1}));
        rst_n = 1'b0;
        tick();
        check_output("mid_rst", 32'({state, ram_req, pc}), 32'd0);
        rst_n = 1'b1; ram_operand = 1'b0;
        ram_ack = 1'b1; ram_rdata = 8'hEE;
        tick();
        ram_ack = 1'b0;
        check_output("stray_ram_ack", 32'({state, operand_q, pc, ram_req}), 32'd0);
        rom_ack = 1'b1; rom_data = 8'h77;
        tick();
        rom_ack = 1'b0;
        check_output("stray_rom_ack", 32'({state, opcode_q, pc}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpuy_sequencer.md
Name: cpuy_sequencer

Overview:
Instruction sequencer for the cpuy 8-bit core. It fetches opcode and operand bytes from program ROM and holds the opcode stable for the combinational ucode decoder. It walks the instruction through RAM-operand read, execute, optional high-byte writeback and stack phases, and owns the program counter, including taken jumps. Sits between program ROM / data RAM and the ucode + ALU datapath.

Parameters:
PC_WIDTH, 8, program counter width; address space 2^PC_WIDTH bytes
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
run  in  1  1 = sequencer may start a new instruction
rom_req  out  1  program ROM read request, held until ack
rom_addr  out  PC_WIDTH  equals pc
rom_ack  in  1  ROM data valid this cycle
rom_data  in  8  ROM byte
ram_req  out  1  data RAM read request, held until ack
ram_addr  out  8  equals operand_q
ram_ack  in  1  RAM data valid this cycle
ram_rdata  in  8  RAM byte
opcode_q  out  8  latched opcode, drives ucode.opcode
operand_q  out  8  latched immediate, or RAM data when ram_operand
ram_operand  in  1  from ucode
alu_multibyte_result  in  1  from ucode
jump_operation  in  1  from ucode
jump_condition  in  1  from ucode, already evaluated against flags
stack_operation  in  1  from ucode
stack_direction  in  1  from ucode; 0 pop, 1 push
exec_en  out  1  one-cycle execute/commit strobe
wb_hi  out  1  one-cycle strobe: write high result byte
sp_push  out  1  one-cycle stack push strobe
sp_pop  out  1  one-cycle stack pop strobe
instr_done  out  1  pulse on the last cycle of each instruction
pc  out  PC_WIDTH  program counter
state  out  3  current FSM state, for debug

Behaviour:
- Reset (rst_n=0 at a clk edge, from any state): state=S_FETCH, pc=RESET_PC, opcode_q=0, operand_q=0. All strobes and requests are 0. An in-flight request is abandoned; a late ack in S_FETCH after reset is ignored unless rom_req=1.
- Encoding: S_FETCH=0, S_OPERAND=1, S_RAM=2, S_EXEC=3, S_WBHI=4, S_STACK=5. Codes 6 and 7 go to S_FETCH.
- S_FETCH: rom_req = run. When rom_req & rom_ack: opcode_q<=rom_data, pc<=pc+1, go to S_OPERAND. rom_ack with rom_req=0 is ignored. If run drops while waiting, rom_req drops and the state holds.
- S_OPERAND: rom_req=1 regardless of run. On rom_ack: operand_q<=rom_data, pc<=pc+1, next state is S_RAM if ram_operand else S_EXEC.
- S_RAM: ram_req=1. On ram_ack: operand_q<=ram_rdata, go to S_EXEC.
- S_EXEC, exactly 1 cycle: exec_en=1. If jump_operation & jump_condition: pc<={zero-extended operand_q} (truncated to PC_WIDTH). Next state is S_WBHI if alu_multibyte_result, else S_STACK if stack_operation, else S_FETCH.
- S_WBHI, 1 cycle: wb_hi=1. Next state is S_STACK if stack_operation, else S_FETCH.
- S_STACK, 1 cycle: sp_push=stack_direction, sp_pop=~stack_direction. Next state is S_FETCH.
- instr_done=1 in the cycle whose next state is S_FETCH.
- opcode_q only changes in S_FETCH, so ucode inputs stay stable for the whole instruction.
- pc increments wrap from 2^PC_WIDTH-1 to 0. A taken jump overrides the increment.
- Requests are registered-state decodes. The same-cycle ack (req and ack both high) completes in 1 cycle. Minimum instruction length is 3 cycles: FETCH, OPERAND, EXEC.
- The only outputs that may be high simultaneously are exec_en with instr_done, wb_hi with instr_done, and sp_* with instr_done.

Decomposition:
- cpuy_pkg holds the state localparams (S_FETCH..S_STACK) and STATE_W=3. ucode reuses the package for shared opcode constants.
- No sub-module. Single FSM plus pc/opcode/operand registers. ucode is instantiated beside it at the core level, not inside it.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 clks, then run=0 -> state=0, pc=0, rom_req=0, all strobes 0 indefinitely.
- Plain ALU op: ROM returns 0x12, 0x34 with immediate acks, decoder flags all 0 -> opcode_q=0x12, operand_q=0x34, exec_en on the 3rd cycle with instr_done, pc=2.
- RAM operand + multibyte: ram_operand=1, ack delayed 3 clks with ram_rdata=0xA5, alu_multibyte_result=1 -> operand_q=0xA5 before exec_en; wb_hi the cycle after exec_en; instr_done coincides with wb_hi.
- Jump: pc=0xFE, jump_operation=1. With jump_condition=1 and operand 0x40 -> pc=0x40 after EXEC. With jump_condition=0 -> pc wraps 0xFE->0x00.
- Stack push then pop: stack_operation=1, stack_direction=1 then 0 -> one-cycle sp_push, then sp_pop, each one cycle after exec_en, never both at once.
- Reset mid-instruction: assert rst_n=0 during S_RAM with ram_req=1 -> next cycle state=0, ram_req=0, pc=0; a subsequent stray ram_ack has no effect.
